// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_W data bits LSB first, optional parity, 1/2 stop bits.
// Define UART_TX_HOLD_EN to add a one-word holding register for gap-free back-to-back frames.
module uart_tx_param #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 20,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        parity_mode,
   input  logic              two_stop,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       IDX_MAX = 4'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        idx_q, idx_d;
   logic [DATA_W-1:0] shr_q, shr_d;
   logic              par_en_q, par_en_d;
   logic              par_q, par_d;
   logic              two_q, two_d;
   logic              stop2_q, stop2_d;
   logic              tx_q, tx_d;

   logic              bit_end, last_stop, accept, ld;
   logic [DATA_W-1:0] ld_data;
   logic [1:0]        ld_mode;
   logic              ld_two;

   assign bit_end    = (cnt_q == CNT_MAX);
   assign last_stop  = (state_q == STOP) && bit_end && (!two_q || stop2_q);
   assign accept     = tx_valid && tx_ready;
   assign frame_done = last_stop;
   assign busy       = (state_q != IDLE);
   assign tx         = tx_q;

`ifdef UART_TX_HOLD_EN
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic [1:0]        hold_mode_q, hold_mode_d;
   logic              hold_two_q, hold_two_d;

   assign tx_ready = !hold_full_q && !rst;

   // A word accepted while idle or on the final stop cycle bypasses the holder.
   always_comb begin
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      hold_mode_d = hold_mode_q;
      hold_two_d  = hold_two_q;
      ld          = 1'b0;
      ld_data     = tx_data;
      ld_mode     = parity_mode;
      ld_two      = two_stop;
      if (last_stop && hold_full_q) begin
         ld          = 1'b1;
         ld_data     = hold_data_q;
         ld_mode     = hold_mode_q;
         ld_two      = hold_two_q;
         hold_full_d = 1'b0;
      end else if (accept) begin
         if ((state_q == IDLE) || last_stop) begin
            ld = 1'b1;
         end else begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
            hold_mode_d = parity_mode;
            hold_two_d  = two_stop;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         hold_mode_q <= 2'b00;
         hold_two_q  <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         hold_mode_q <= hold_mode_d;
         hold_two_q  <= hold_two_d;
      end
   end
`else
   assign tx_ready = (state_q == IDLE) && !rst;

   always_comb begin
      ld      = accept;
      ld_data = tx_data;
      ld_mode = parity_mode;
      ld_two  = two_stop;
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = ((state_q == IDLE) || bit_end) ? '0 : cnt_q + 1'b1;
      idx_d    = idx_q;
      shr_d    = shr_q;
      par_en_d = par_en_q;
      par_d    = par_q;
      two_d    = two_q;
      stop2_d  = stop2_q;
      case (state_q)
         IDLE:   ;
         START:  if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 4'd0;
                 end
         DATA:   if (bit_end) begin
                    if (idx_q == IDX_MAX) begin
                       state_d = par_en_q ? PARITY : STOP;
                       stop2_d = 1'b0;
                    end else begin
                       idx_d = idx_q + 4'd1;
                       shr_d = shr_q >> 1;
                    end
                 end
         PARITY: if (bit_end) begin
                    state_d = STOP;
                    stop2_d = 1'b0;
                 end
         STOP:   if (bit_end) begin
                    if (two_q && !stop2_q) stop2_d = 1'b1;
                    else                   state_d = IDLE;
                 end
         default: state_d = IDLE;
      endcase
      // Loads only happen in IDLE or on the last stop cycle; parity is precomputed here.
      if (ld) begin
         state_d  = START;
         shr_d    = ld_data;
         par_en_d = (ld_mode == 2'b01) || (ld_mode == 2'b10);
         par_d    = (^ld_data) ^ (ld_mode == 2'b10);
         two_d    = ld_two;
         stop2_d  = 1'b0;
      end
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shr_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= 4'd0;
         shr_q    <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         two_q    <= 1'b0;
         stop2_q  <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shr_q    <= shr_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         two_q    <= two_d;
         stop2_q  <= stop2_d;
         tx_q     <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: an 8-bit/20-clk and a 5-bit/4-clk instance checked every cycle
// against a frame-level model, plus literal frame length / bit pattern expectations.
module tb_uart_tx_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;

   logic [7:0] d8 = '0;  logic v8 = 1'b0;  logic [1:0] pm8 = 2'b00;  logic ts8 = 1'b0;
   logic [4:0] d5 = '0;  logic v5 = 1'b0;  logic [1:0] pm5 = 2'b00;  logic ts5 = 1'b0;
   logic rdy8, tx8, bsy8, fd8;
   logic rdy5, tx5, bsy5, fd5;

   uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(20)) u8 (
      .clk(clk), .rst(rst), .tx_data(d8), .tx_valid(v8), .tx_ready(rdy8),
      .parity_mode(pm8), .two_stop(ts8), .tx(tx8), .busy(bsy8), .frame_done(fd8));

   uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(4)) u5 (
      .clk(clk), .rst(rst), .tx_data(d5), .tx_valid(v5), .tx_ready(rdy5),
      .parity_mode(pm5), .two_stop(ts5), .tx(tx5), .busy(bsy5), .frame_done(fd5));

`ifdef UART_TX_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   typedef struct packed { logic tx; logic fd; } ent_t;

   ent_t q8[$];
   ent_t q5[$];
   int   nf8 = 0, nf5 = 0, acc8 = 0, acc5 = 0;
   bit   armed = 1'b0;
   int   tests = 0, fails = 0;

   // Serial bit sequence of one frame, index 0 = start bit.
   function automatic int build(input logic [8:0] d, input int dw, input logic [1:0] pm,
                                input logic ts, output logic [15:0] fb);
      int   n;
      logic p;
      fb = '0;
      p  = 1'b0;
      for (int i = 0; i < dw; i++) begin
         fb[1+i] = d[i];
         p       = p ^ d[i];
      end
      n = 1 + dw;
      if (pm == 2'b01 || pm == 2'b10) begin
         fb[n] = p ^ (pm == 2'b10);
         n++;
      end
      fb[n] = 1'b1;
      n++;
      if (ts) begin
         fb[n] = 1'b1;
         n++;
      end
      return n;
   endfunction

   function automatic bit mrdy(input int nf);
      return !rst && (HOLD ? (nf < 2) : (nf == 0));
   endfunction

   // Model: queue of expected per-cycle (tx, frame_done); head is the current cycle.
   always @(posedge clk) begin
      bit r; ent_t e; logic [15:0] fb; int n;
      r = mrdy(nf8);
      if (q8.size() > 0) begin
         e = q8.pop_front();
         if (e.fd) nf8--;
      end
      if (rst) begin
         q8.delete(); nf8 = 0; armed = 1'b1;
      end else if (v8 && r) begin
         n = build({1'b0, d8}, 8, pm8, ts8, fb);
         for (int b = 0; b < n; b++)
            for (int c = 0; c < 20; c++)
               q8.push_back('{tx: fb[b], fd: (b == n-1 && c == 19)});
         nf8++; acc8++;
      end
   end

   always @(posedge clk) begin
      bit r; ent_t e; logic [15:0] fb; int n;
      r = mrdy(nf5);
      if (q5.size() > 0) begin
         e = q5.pop_front();
         if (e.fd) nf5--;
      end
      if (rst) begin
         q5.delete(); nf5 = 0;
      end else if (v5 && r) begin
         n = build({4'b0, d5}, 5, pm5, ts5, fb);
         for (int b = 0; b < n; b++)
            for (int c = 0; c < 4; c++)
               q5.push_back('{tx: fb[b], fd: (b == n-1 && c == 3)});
         nf5++; acc5++;
      end
   end

   // Frame monitors: frame length, gap since previous frame_done, tx sampled mid-bit.
   int cyc = 0;
   int st8 = 0, fdc8 = -100, len8 = 0, gap8 = 0, fc8 = 0;
   int st5 = 0, len5 = 0, fc5 = 0;
   logic [15:0] mb8 = '0, fmb8 = '0, mb5 = '0, fmb5 = '0;
   logic pb8 = 1'b0, pf8 = 1'b0, pb5 = 1'b0, pf5 = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (armed) begin
         if (bsy8 && (!pb8 || pf8)) begin st8 = cyc; gap8 = cyc - fdc8; mb8 = '0; end
         if (bsy8 && ((cyc - st8) % 20 == 10)) mb8[(cyc - st8) / 20] = tx8;
         if (fd8) begin fdc8 = cyc; len8 = cyc - st8 + 1; fmb8 = mb8; fc8++; end
         pb8 = bsy8; pf8 = fd8;
         if (bsy5 && (!pb5 || pf5)) begin st5 = cyc; mb5 = '0; end
         if (bsy5 && ((cyc - st5) % 4 == 2)) mb5[(cyc - st5) / 4] = tx5;
         if (fd5) begin len5 = cyc - st5 + 1; fmb5 = mb5; fc5++; end
         pb5 = bsy5; pf5 = fd5;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send8(input logic [7:0] d, input logic [1:0] pm, input logic ts, input bit keep);
      int a;
      a = acc8; d8 = d; pm8 = pm; ts8 = ts; v8 = 1'b1;
      for (int i = 0; i < 600 && acc8 == a; i++) tick(1);
      if (acc8 == a) check("accept8_timeout", 0, 1);
      v8 = keep;
   endtask

   task automatic send5(input logic [4:0] d, input logic [1:0] pm, input logic ts);
      int a;
      a = acc5; d5 = d; pm5 = pm; ts5 = ts; v5 = 1'b1;
      for (int i = 0; i < 100 && acc5 == a; i++) tick(1);
      if (acc5 == a) check("accept5_timeout", 0, 1);
      v5 = 1'b0;
   endtask

   task automatic wait8(input int k);
      int f;
      f = fc8;
      for (int i = 0; i < 2000 && fc8 < f + k; i++) tick(1);
      if (fc8 < f + k) check("frame8_timeout", fc8, f + k);
   endtask

   task automatic wait5;
      int f;
      f = fc5;
      for (int i = 0; i < 200 && fc5 == f; i++) tick(1);
      if (fc5 == f) check("frame5_timeout", fc5, f + 1);
   endtask

   initial begin
      logic [15:0] fb;
      int n, f;
      fork
         forever begin
            @(negedge clk);
            if (armed) begin
               check("cycle8 {tx,busy,fd,rdy}", {tx8, bsy8, fd8, rdy8},
                     (q8.size() > 0) ? {q8[0].tx, 1'b1, q8[0].fd, mrdy(nf8)} : {3'b100, mrdy(nf8)});
               check("cycle5 {tx,busy,fd,rdy}", {tx5, bsy5, fd5, rdy5},
                     (q5.size() > 0) ? {q5[0].tx, 1'b1, q5[0].fd, mrdy(nf5)} : {3'b100, mrdy(nf5)});
            end
         end
      join_none

      tick(3);
      check("rst_tx", tx8, 1'b1);
      check("rst_busy", bsy8, 1'b0);
      check("rst_fd", fd8, 1'b0);
      check("rst_ready", rdy8, 1'b0);
      rst = 1'b0;
      tick(2);
      check("idle_ready", rdy8, 1'b1);

      n = build(9'h0A5, 8, 2'b00, 1'b0, fb);
      check("model_A5_len", n, 10);
      check("model_A5_bits", fb[9:0], 10'h34A);
      n = build(9'h01F, 5, 2'b10, 1'b0, fb);
      check("model_1F_len", n, 8);
      check("model_1F_bits", fb[7:0], 8'hBE);

      // Basic frame
      send8(8'hA5, 2'b00, 1'b0, 1'b0);
      wait8(1);
      check("t1_len", len8, 200);
      check("t1_bits", fmb8[9:0], 10'h34A);
      check("t1_busy_after", bsy8, 1'b0);

      // Parity and two stop bits
      send8(8'h07, 2'b01, 1'b0, 1'b0);
      wait8(1);
      check("t2_even_par", fmb8[9], 1'b1);
      check("t2_even_len", len8, 220);
      send8(8'h07, 2'b10, 1'b0, 1'b0);
      wait8(1);
      check("t2_odd_par", fmb8[9], 1'b0);
      send8(8'h07, 2'b01, 1'b1, 1'b0);
      wait8(1);
      check("t2_2stop_len", len8, 240);
      check("t2_2stop_bits", fmb8[11:9], 3'b111);

      // Back-to-back with tx_valid held
      f = fc8;
      send8(8'h11, 2'b00, 1'b0, 1'b1);
      send8(8'h22, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 1000 && fc8 < f + 2; i++) tick(1);
      check("t3_frames", fc8, f + 2);
      check("t3_gap", gap8, HOLD ? 1 : 2);
      check("t3_bits2", fmb8[9:0], 10'h244);

      // Reset during data bit 3
      send8(8'h00, 2'b00, 1'b0, 1'b0);
      tick(85);
      f = fc8;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check("t4_tx_after_rst", tx8, 1'b1);
      check("t4_busy_after_rst", bsy8, 1'b0);
      check("t4_no_fd", fc8, f);
      tick(1);
      send8(8'h3C, 2'b00, 1'b0, 1'b0);
      wait8(1);
      check("t4_len", len8, 200);
      check("t4_bits", fmb8[9:0], 10'h278);

      // Inputs change mid-frame while tx_valid is low
      send8(8'h5A, 2'b00, 1'b0, 1'b0);
      tick(30);
      d8 = 8'hFF; pm8 = 2'b01; ts8 = 1'b1;
      tick(30);
      d8 = 8'h00; pm8 = 2'b10;
      wait8(1);
      check("t5_len", len8, 200);
      check("t5_bits", fmb8[9:0], 10'h2B4);
      pm8 = 2'b00; ts8 = 1'b0;

      // Narrow instance
      send5(5'h1F, 2'b10, 1'b0);
      wait5;
      check("t6_len", len5, 32);
      check("t6_bits", fmb5[7:0], 8'hBE);

      tick(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. Serialises one DATA_W-bit word per frame: start bit, data LSB-first, optional parity, 1 or 2 stop bits. Accepts words over a valid/ready handshake and exposes busy and frame-done status. Successor to the fixed 8-bit, fixed-parity transmitter in the serial TX path. It drives the pad-side tx line directly.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 20, clk cycles per serial bit; legal range 2 and up.
CNT_W, $clog2(CLKS_PER_BIT), baud counter width. Derived; not overridden.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
tx_data  input  DATA_W  word to send; sampled on handshake.
tx_valid  input  1  tx_data valid.
tx_ready  output  1  block can accept a word this cycle.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none. Sampled on handshake.
two_stop  input  1  1 = two stop bits, 0 = one. Sampled on handshake.
tx  output  1  serial line, registered, idle high.
busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse on the last cycle of the last stop bit.

Behaviour:
- Reset (rst high at an edge): next-cycle values are tx=1, busy=0, frame_done=0, state=IDLE, counters=0, holding register empty.
- tx_ready=0 while rst is high.
- Reset mid-frame aborts the frame immediately. No frame_done pulse.
- Handshake: a word is accepted on an edge where tx_valid && tx_ready.
- tx_data, parity_mode and two_stop are captured at accept. Later changes do not affect that frame.
- tx_valid held while tx_ready=0 has no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on accept. tx=0 from the cycle after accept.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA: bit index 0..DATA_W-1, shifted out LSB first. Each bit lasts CLKS_PER_BIT cycles.
- DATA -> PARITY if mode is 01 or 10, otherwise DATA -> STOP.
- PARITY bit value:
  - even: XOR of the data bits.
  - odd: inverted XOR of the data bits.
  - PARITY lasts CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT cycles when two_stop=1.
- frame_done pulses on the final cycle of STOP. Next state is IDLE, or START if the optional feature is enabled and a word is held.
- Frame length = CLKS_PER_BIT*(1+DATA_W+P+S), where P is 0/1 and S is 1/2.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Held at 0 in IDLE.
- busy=1 in every state except IDLE.
- tx_ready = (state==IDLE) && !rst. tx_ready depends combinationally on state only, not on tx_valid.
- Back-to-back frames (feature off): at least one IDLE cycle with tx=1 sits between the last stop bit and the next start bit.

Optional Feature:
UART_TX_HOLD_EN
- Defined: adds a one-word holding register (data + config).
  - tx_ready = holding empty && !rst, so a word can be accepted during a frame.
  - At the end of STOP with holding full: go directly to START with zero idle cycles, load the shifter, empty the holding register.
  - A simultaneous end-of-frame and accept into an empty holder starts that word immediately on the next cycle.
  - Reset clears the holder.
- Undefined: no holding register; behaviour as in Behaviour above.

Test Plan:
1. DATA_W=8, CLKS_PER_BIT=20, parity 00, two_stop=0, send 0xA5 -> tx shows 0,1,0,1,0,0,1,0,1,1, each 20 cycles. frame_done 200 cycles after the first tx=0 cycle (on its last cycle). busy drops the cycle after.
2. Send 0x07 with parity 01 -> parity bit 1. Same word with parity 10 -> parity bit 0. two_stop=1 -> tx high for 40 cycles ending with frame_done; frame length 240 cycles.
3. Two words offered back-to-back with tx_valid held:
   - feature off: exactly 1 idle-high cycle between frames.
   - UART_TX_HOLD_EN: second word accepted during the first frame; its start bit begins the cycle after the first frame_done.
4. Assert rst for 1 cycle during data bit 3 -> next cycle tx=1, busy=0, no frame_done. A following send of 0x3C is transmitted correctly.
5. Change tx_data, parity_mode and two_stop mid-frame while tx_ready=0 -> current frame is unchanged.
6. DATA_W=5, CLKS_PER_BIT=4, parity 10, send 5'h1F -> bits 0,1,1,1,1,1,0,1 at 4 cycles each. Frame length 32 cycles.
